// File: rtl/alu_rs_sched.sv
// Reservation-station scheduler for the integer ALU: holds dispatched micro-ops,
// captures operands from two CDB ports and issues one ready entry per cycle round-robin.
module alu_rs_sched #(
  parameter int unsigned RS_SIZE   = 8,
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned OP_WIDTH  = 9
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 disp_valid,
  input  logic [OP_WIDTH-1:0]  disp_op,
  input  logic [ROB_WIDTH-1:0] disp_rob_id,
  input  logic [31:0]          disp_vj,
  input  logic                 disp_qj_valid,
  input  logic [ROB_WIDTH-1:0] disp_qj,
  input  logic [31:0]          disp_vk,
  input  logic                 disp_qk_valid,
  input  logic [ROB_WIDTH-1:0] disp_qk,
  output logic                 full,
  input  logic                 cdb0_valid,
  input  logic [ROB_WIDTH-1:0] cdb0_rob_id,
  input  logic [31:0]          cdb0_value,
  input  logic                 cdb1_valid,
  input  logic [ROB_WIDTH-1:0] cdb1_rob_id,
  input  logic [31:0]          cdb1_value,
  output logic                 calc_enable,
  output logic [31:0]          lhs,
  output logic [31:0]          rhs,
  output logic [OP_WIDTH-1:0]  op,
  output logic [ROB_WIDTH-1:0] rob_dep
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0]   r_busy;
  logic [RS_SIZE-1:0]   r_qj_valid;
  logic [RS_SIZE-1:0]   r_qk_valid;
  logic [OP_WIDTH-1:0]  r_op     [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_rob_id [RS_SIZE];
  logic [31:0]          r_vj     [RS_SIZE];
  logic [31:0]          r_vk     [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qj     [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qk     [RS_SIZE];
  logic [CNT_W-1:0]     r_count;
  logic [IDX_W-1:0]     r_rr_ptr;

  logic                 r_calc_enable;
  logic [31:0]          r_lhs;
  logic [31:0]          r_rhs;
  logic [OP_WIDTH-1:0]  r_op_out;
  logic [ROB_WIDTH-1:0] r_rob_dep;

  logic                 w_accept;
  logic                 w_free_found;
  logic [IDX_W-1:0]     w_free_idx;
  logic [RS_SIZE-1:0]   w_ready;
  logic                 w_issue;
  logic [IDX_W-1:0]     w_issue_idx;
  logic [IDX_W-1:0]     w_scan;
  logic [31:0]          w_dj_val;
  logic                 w_dj_pend;
  logic [31:0]          w_dk_val;
  logic                 w_dk_pend;

  assign full        = (r_count == CNT_W'(RS_SIZE));
  assign w_accept    = disp_valid & ~full & rdy_in & ~clear & ~rst_in & w_free_found;
  assign w_ready     = r_busy & ~r_qj_valid & ~r_qk_valid;

  assign calc_enable = r_calc_enable;
  assign lhs         = r_lhs;
  assign rhs         = r_rhs;
  assign op          = r_op_out;
  assign rob_dep     = r_rob_dep;

  // Lowest-index free slot for dispatch
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // First ready entry at or after rr_ptr; scanning backwards leaves the nearest one
  always_comb begin
    w_issue     = 1'b0;
    w_issue_idx = '0;
    w_scan      = '0;
    for (int k = int'(RS_SIZE) - 1; k >= 0; k--) begin
      w_scan = r_rr_ptr + IDX_W'(k);
      if (w_ready[w_scan]) begin
        w_issue     = 1'b1;
        w_issue_idx = w_scan;
      end
    end
  end

  // Dispatch-time bypass from the CDB; port 0 has priority
  always_comb begin
    w_dj_val  = disp_vj;
    w_dj_pend = disp_qj_valid;
    w_dk_val  = disp_vk;
    w_dk_pend = disp_qk_valid;
    if (disp_qj_valid && cdb0_valid && (cdb0_rob_id == disp_qj)) begin
      w_dj_val  = cdb0_value;
      w_dj_pend = 1'b0;
    end else if (disp_qj_valid && cdb1_valid && (cdb1_rob_id == disp_qj)) begin
      w_dj_val  = cdb1_value;
      w_dj_pend = 1'b0;
    end
    if (disp_qk_valid && cdb0_valid && (cdb0_rob_id == disp_qk)) begin
      w_dk_val  = cdb0_value;
      w_dk_pend = 1'b0;
    end else if (disp_qk_valid && cdb1_valid && (cdb1_rob_id == disp_qk)) begin
      w_dk_val  = cdb1_value;
      w_dk_pend = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy        <= '0;
      r_count       <= '0;
      r_rr_ptr      <= '0;
      r_calc_enable <= 1'b0;
      r_lhs         <= '0;
      r_rhs         <= '0;
      r_op_out      <= '0;
      r_rob_dep     <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy        <= '0;
        r_count       <= '0;
        r_calc_enable <= 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          // Wakeup only touches busy entries; dispatch only touches a free one
          if (r_busy[i] && r_qj_valid[i]) begin
            if (cdb0_valid && (cdb0_rob_id == r_qj[i])) begin
              r_vj[i]       <= cdb0_value;
              r_qj_valid[i] <= 1'b0;
            end else if (cdb1_valid && (cdb1_rob_id == r_qj[i])) begin
              r_vj[i]       <= cdb1_value;
              r_qj_valid[i] <= 1'b0;
            end
          end
          if (r_busy[i] && r_qk_valid[i]) begin
            if (cdb0_valid && (cdb0_rob_id == r_qk[i])) begin
              r_vk[i]       <= cdb0_value;
              r_qk_valid[i] <= 1'b0;
            end else if (cdb1_valid && (cdb1_rob_id == r_qk[i])) begin
              r_vk[i]       <= cdb1_value;
              r_qk_valid[i] <= 1'b0;
            end
          end
          if (w_accept && (IDX_W'(i) == w_free_idx)) begin
            r_busy[i]     <= 1'b1;
            r_op[i]       <= disp_op;
            r_rob_id[i]   <= disp_rob_id;
            r_vj[i]       <= w_dj_val;
            r_qj_valid[i] <= w_dj_pend;
            r_qj[i]       <= disp_qj;
            r_vk[i]       <= w_dk_val;
            r_qk_valid[i] <= w_dk_pend;
            r_qk[i]       <= disp_qk;
          end
          if (w_issue && (IDX_W'(i) == w_issue_idx)) begin
            r_busy[i] <= 1'b0;
          end
        end
        r_calc_enable <= w_issue;
        if (w_issue) begin
          r_lhs     <= r_vj[w_issue_idx];
          r_rhs     <= r_vk[w_issue_idx];
          r_op_out  <= r_op[w_issue_idx];
          r_rob_dep <= r_rob_id[w_issue_idx];
          r_rr_ptr  <= w_issue_idx + IDX_W'(1);
        end
        r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched: reset, issue latency, wakeup/bypass, full,
// round-robin order, flush and stall.
module tb_alu_rs_sched;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, disp_valid;
  logic [8:0]  disp_op;
  logic [3:0]  disp_rob_id, disp_qj, disp_qk;
  logic [31:0] disp_vj, disp_vk;
  logic        disp_qj_valid, disp_qk_valid;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_rob_id, cdb1_rob_id;
  logic [31:0] cdb0_value, cdb1_value;
  logic        calc_enable;
  logic [31:0] lhs, rhs;
  logic [8:0]  op;
  logic [3:0]  rob_dep;

  int n_vec = 0;
  int n_bad = 0;
  logic [78:0] obs, e;

  alu_rs_sched dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_rob_id(disp_rob_id),
    .disp_vj(disp_vj), .disp_qj_valid(disp_qj_valid), .disp_qj(disp_qj),
    .disp_vk(disp_vk), .disp_qk_valid(disp_qk_valid), .disp_qk(disp_qk),
    .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op), .rob_dep(rob_dep)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {calc_enable, full, op, rob_dep, lhs, rhs};

  function automatic logic [78:0] ex(input logic ce, input logic fu, input logic [8:0] o,
                                     input logic [3:0] rb, input logic [31:0] l,
                                     input logic [31:0] r);
    return {ce, fu, o, rb, l, r};
  endfunction

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    disp_valid = 1'b0; disp_op = 9'h0; disp_rob_id = 4'h0;
    disp_vj = 32'h0; disp_qj_valid = 1'b0; disp_qj = 4'h0;
    disp_vk = 32'h0; disp_qk_valid = 1'b0; disp_qk = 4'h0;
    cdb0_valid = 1'b0; cdb0_rob_id = 4'h0; cdb0_value = 32'h0;
    cdb1_valid = 1'b0; cdb1_rob_id = 4'h0; cdb1_value = 32'h0;
  endtask

  task automatic do_reset;
    idle();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic set_disp(input logic [8:0] o, input logic [3:0] rb,
                          input logic [31:0] vj, input logic qjv, input logic [3:0] qj,
                          input logic [31:0] vk, input logic qkv, input logic [3:0] qk);
    disp_valid = 1'b1; disp_op = o; disp_rob_id = rb;
    disp_vj = vj; disp_qj_valid = qjv; disp_qj = qj;
    disp_vk = vk; disp_qk_valid = qkv; disp_qk = qk;
  endtask

  task automatic set_cdb0(input logic [3:0] t, input logic [31:0] v);
    cdb0_valid = 1'b1; cdb0_rob_id = t; cdb0_value = v;
  endtask

  task automatic set_cdb1(input logic [3:0] t, input logic [31:0] v);
    cdb1_valid = 1'b1; cdb1_rob_id = t; cdb1_value = v;
  endtask

  task automatic test_reset;
    idle();
    rdy_in = 1'b0;
    rst_in = 1'b1;
    step();
    step();
    e = ex(1'b0, 1'b0, 9'h0, 4'h0, 32'h0, 32'h0);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_state got %h want %h", obs, e); end
    idle();
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL reset_idle[%0d] got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_ready;
    do_reset();
    set_disp(9'h001, 4'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
    step();
    idle();
    e = ex(1'b0, 1'b0, 9'h0, 4'h0, 32'h0, 32'h0);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ready_dispatch_edge got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h001, 4'd3, 32'd5, 32'd7);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ready_issue got %h want %h", obs, e); end
    step();
    e = ex(1'b0, 1'b0, 9'h001, 4'd3, 32'd5, 32'd7);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ready_one_pulse got %h want %h", obs, e); end
  endtask

  task automatic test_wakeup;
    do_reset();
    set_disp(9'h002, 4'd6, 32'h0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0);
    step();
    idle();
    set_cdb1(4'd2, 32'h10);
    step();
    idle();
    e = ex(1'b0, 1'b0, 9'h0, 4'h0, 32'h0, 32'h0);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL wakeup_not_same_cycle got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h002, 4'd6, 32'h10, 32'd1);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL wakeup_cdb1_issue got %h want %h", obs, e); end
    // Dispatch-time bypass of a pending rhs
    set_disp(9'h003, 4'd7, 32'd3, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4);
    set_cdb0(4'd4, 32'd9);
    step();
    idle();
    e = ex(1'b0, 1'b0, 9'h002, 4'd6, 32'h10, 32'd1);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL bypass_hold got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h003, 4'd7, 32'd3, 32'd9);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL bypass_issue got %h want %h", obs, e); end
    // Same tag on both CDB ports: port 0 value is captured
    set_disp(9'h004, 4'd8, 32'h0, 1'b1, 4'd5, 32'd2, 1'b0, 4'd0);
    step();
    idle();
    set_cdb0(4'd5, 32'hAA);
    set_cdb1(4'd5, 32'hBB);
    step();
    idle();
    step();
    e = ex(1'b1, 1'b0, 9'h004, 4'd8, 32'hAA, 32'd2);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL cdb_port0_priority got %h want %h", obs, e); end
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_disp(9'h010, 4'(i), 32'h0, 1'b1, 4'(8 + i), 32'(i), 1'b0, 4'd0);
      step();
    end
    idle();
    e = ex(1'b0, 1'b1, 9'h0, 4'h0, 32'h0, 32'h0);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL full_after_8 got %h want %h", obs, e); end
    set_disp(9'h011, 4'd15, 32'h99, 1'b0, 4'd0, 32'h98, 1'b0, 4'd0);
    step();
    idle();
    step();
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL full_reject_9th got %h want %h", obs, e); end
    set_cdb0(4'd10, 32'h22);
    step();
    idle();
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL full_wake_edge got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h010, 4'd2, 32'h22, 32'd2);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL full_drop_issue got %h want %h", obs, e); end
    // Dispatch and issue on the same edge keep count at 7
    set_cdb0(4'd12, 32'h44);
    step();
    idle();
    set_disp(9'h012, 4'd13, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0);
    step();
    idle();
    e = ex(1'b1, 1'b0, 9'h010, 4'd4, 32'h44, 32'd4);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL disp_issue_same got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h012, 4'd13, 32'h55, 32'h66);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL disp_issue_new got %h want %h", obs, e); end
    set_disp(9'h013, 4'd14, 32'h0, 1'b1, 4'd1, 32'h0, 1'b0, 4'd0);
    step();
    e = ex(1'b0, 1'b0, 9'h012, 4'd13, 32'h55, 32'h66);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL count_7 got %h want %h", obs, e); end
    step();
    idle();
    e = ex(1'b0, 1'b1, 9'h012, 4'd13, 32'h55, 32'h66);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL count_8 got %h want %h", obs, e); end
  endtask

  task automatic test_round_robin;
    logic [3:0] tg [8];
    tg = '{4'd8, 4'd9, 4'd10, 4'd8, 4'd10, 4'd8, 4'd10, 4'd11};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_disp(9'h020, 4'(i), 32'h0, 1'b1, tg[i], 32'(i), 1'b0, 4'd0);
      step();
    end
    idle();
    // Drain slots 1 and 7 first so rr_ptr wraps back to 0 with slot 1 free
    set_cdb0(4'd9, 32'h91);
    set_cdb1(4'd11, 32'hB1);
    step();
    idle();
    e = ex(1'b0, 1'b1, 9'h0, 4'h0, 32'h0, 32'h0);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_wake_edge got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h020, 4'd1, 32'h91, 32'd1);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_issue_1 got %h want %h", obs, e); end
    set_cdb0(4'd8, 32'h80);
    step();
    idle();
    e = ex(1'b1, 1'b0, 9'h020, 4'd7, 32'hB1, 32'd7);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_issue_7 got %h want %h", obs, e); end
    set_disp(9'h021, 4'd12, 32'h0, 1'b1, 4'd12, 32'h0C, 1'b0, 4'd0);
    step();
    idle();
    e = ex(1'b1, 1'b0, 9'h020, 4'd0, 32'h80, 32'd0);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_order_0 got %h want %h", obs, e); end
    set_cdb1(4'd12, 32'hC0);
    step();
    idle();
    e = ex(1'b1, 1'b0, 9'h020, 4'd3, 32'h80, 32'd3);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_order_3 got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h020, 4'd5, 32'h80, 32'd5);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_order_5 got %h want %h", obs, e); end
    step();
    e = ex(1'b1, 1'b0, 9'h021, 4'd12, 32'hC0, 32'h0C);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_order_slot1 got %h want %h", obs, e); end
    step();
    e = ex(1'b0, 1'b0, 9'h021, 4'd12, 32'hC0, 32'h0C);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL rr_drained got %h want %h", obs, e); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_disp(9'h030, 4'(i), 32'h0, 1'b1, 4'd8, 32'h0, 1'b0, 4'd0);
      step();
    end
    set_disp(9'h031, 4'd10, 32'hA0, 1'b0, 4'd0, 32'hA1, 1'b0, 4'd0);
    step();
    idle();
    step();
    e = ex(1'b1, 1'b0, 9'h031, 4'd10, 32'hA0, 32'hA1);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_pre_issue got %h want %h", obs, e); end
    clear = 1'b1;
    set_disp(9'h032, 4'd11, 32'hB0, 1'b0, 4'd0, 32'hB1, 1'b0, 4'd0);
    set_cdb0(4'd8, 32'd3);
    step();
    idle();
    e = ex(1'b0, 1'b0, 9'h031, 4'd10, 32'hA0, 32'hA1);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_state got %h want %h", obs, e); end
    set_cdb0(4'd8, 32'd3);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL flush_no_issue[%0d] got %h want %h", i, obs, e); end
    end
    for (int i = 0; i < 7; i++) begin
      set_disp(9'h033, 4'(i), 32'h0, 1'b1, 4'd1, 32'h0, 1'b0, 4'd0);
      step();
    end
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_count_7 got %h want %h", obs, e); end
    step();
    idle();
    e = ex(1'b0, 1'b1, 9'h031, 4'd10, 32'hA0, 32'hA1);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_count_8 got %h want %h", obs, e); end
  endtask

  task automatic test_stall;
    do_reset();
    set_disp(9'h040, 4'd1, 32'h11, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0);
    step();
    set_disp(9'h041, 4'd2, 32'h33, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0);
    step();
    e = ex(1'b1, 1'b0, 9'h040, 4'd1, 32'h11, 32'h22);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_pre got %h want %h", obs, e); end
    rdy_in = 1'b0;
    set_disp(9'h042, 4'd3, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL stall_hold[%0d] got %h want %h", i, obs, e); end
    end
    idle();
    step();
    e = ex(1'b1, 1'b0, 9'h041, 4'd2, 32'h33, 32'h44);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_resume got %h want %h", obs, e); end
    step();
    e = ex(1'b0, 1'b0, 9'h041, 4'd2, 32'h33, 32'h44);
    n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_no_accept got %h want %h", obs, e); end
  endtask

  initial begin
    idle();
    test_reset();
    test_ready();
    test_wakeup();
    test_full();
    test_round_robin();
    test_flush();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_rs_sched.md
Name: alu_rs_sched

Overview:
- Reservation-station scheduler for the integer ALU.
- Holds up to RS_SIZE dispatched ALU/branch/jump micro-ops and captures their source operands from two common-data-bus (CDB) broadcast ports.
- Each cycle, issues at most one operand-complete entry to the ALU execution unit using its calc_enable/lhs/rhs/op/rob_dep inputs.
- Sits between the dispatch/rename stage and the ALU execution unit; flushed on branch misprediction.

Parameters:
- RS_SIZE, 8: number of entries; power of two, at least 2.
- ROB_WIDTH, 4: ROB tag width.
- OP_WIDTH, 9: opcode width; the value is carried through unchanged.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global enable; when low, all state and outputs hold
- clear  in  1  misprediction flush
- disp_valid  in  1  dispatch request
- disp_op  in  OP_WIDTH  opcode
- disp_rob_id  in  ROB_WIDTH  destination ROB tag
- disp_vj  in  32  lhs value, used when disp_qj_valid=0
- disp_qj_valid  in  1  lhs still pending
- disp_qj  in  ROB_WIDTH  lhs producer tag
- disp_vk  in  32  rhs value, used when disp_qk_valid=0
- disp_qk_valid  in  1  rhs still pending
- disp_qk  in  ROB_WIDTH  rhs producer tag
- full  out  1  equals (count==RS_SIZE), derived from registered count
- cdb0_valid, cdb1_valid  in  1  broadcast valid (ALU, LSB)
- cdb0_rob_id, cdb1_rob_id  in  ROB_WIDTH  broadcast tag
- cdb0_value, cdb1_value  in  32  broadcast value
- calc_enable  out  1  issue strobe to ALU
- lhs, rhs  out  32  issued operands
- op  out  OP_WIDTH  issued opcode
- rob_dep  out  ROB_WIDTH  issued destination tag

Behaviour:
- Per-entry state: busy, op, rob_id, vj, qj_valid, qj, vk, qk_valid, qk.
- Global state: count (0..RS_SIZE) and round-robin pointer rr_ptr.
- Reset (rst_in=1, regardless of rdy_in), at the clock edge:
  - all busy=0, count=0, rr_ptr=0;
  - calc_enable=0, lhs=0, rhs=0, op=0, rob_dep=0.
- clear (rst_in=0, rdy_in=1, clear=1):
  - same effect as reset on busy, count and calc_enable; rr_ptr and data outputs hold;
  - dispatch and CDB inputs that cycle are ignored.
- rdy_in=0: no register changes; a pending dispatch is not accepted.
- Dispatch acceptance:
  - accepted when disp_valid & ~full & rdy_in & ~clear & ~rst_in;
  - the entry is written into the lowest-index non-busy slot;
  - full is computed from the registered count, so a same-cycle issue does not free space for a dispatch.
- Dispatch-time bypass:
  - if a valid CDB tag equals disp_qj (with disp_qj_valid=1) in the acceptance cycle, the entry stores that CDB value with qj_valid=0;
  - the same rule applies to k.
- Wakeup:
  - for every busy entry with qj_valid=1 and a CDB match, set vj to the CDB value and clear qj_valid; the same applies to k;
  - if both CDB ports carry the same tag, port 0 wins.
- Issue:
  - ready[i] = busy & ~qj_valid & ~qk_valid, computed from registered state only;
  - a wakeup in cycle T makes an entry issuable in T+1 at the earliest.
  - Selection: the first ready index at or after rr_ptr, wrapping modulo RS_SIZE.
  - On issue at the edge:
    - calc_enable<=1; lhs<=vj, rhs<=vk, op, rob_dep<=rob_id;
    - busy[i]<=0;
    - rr_ptr<=(i+1) mod RS_SIZE.
  - If no entry is ready: calc_enable<=0 and the data outputs hold.
- Latency: a dispatch accepted with both operands ready at edge E causes issue at edge E+1; calc_enable is high for exactly one cycle per issue.
- Count: count_next = count + accepted_dispatch - issued; a simultaneous dispatch and issue leaves count unchanged.
- Tags: ROB tags are compared at full ROB_WIDTH. Operand values are stored unmodified; all arithmetic is done in the ALU.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles -> calc_enable=0, full=0, rob_dep=0. No issue occurs for 10 cycles.
- Ready dispatch: op=ADD, vj=5, vk=7, rob_id=3, both q invalid at edge E -> at E+1 calc_enable=1, lhs=5, rhs=7, rob_dep=3. At E+2 calc_enable=0.
- Wakeup and bypass:
  - Entry with qj=2 pending; cdb1 broadcasts tag 2, value 0x10 at edge W -> entry issues at W+1 with lhs=0x10.
  - A dispatch with qk=4 in the same cycle as cdb0 tag 4, value 9 -> issues one edge later with rhs=9.
- Full and simultaneous events:
  - Fill 8 entries, all pending -> full=1; a 9th disp_valid is not accepted.
  - Wake one entry -> it issues; full drops the following cycle.
  - Dispatch + issue in the same cycle -> count unchanged.
- Round-robin fairness: entries 0, 3 and 5 all ready together -> issue order 0, 3, 5 on consecutive edges. A new ready entry at index 1 dispatched after 0 issues only after 3 and 5.
- Flush and stall:
  - clear with 5 busy entries and a concurrent disp_valid -> next cycle calc_enable=0, full=0, nothing issues afterward.
  - rdy_in=0 for 3 cycles with ready entries -> no issue, outputs hold; issue resumes on the first cycle with rdy_in=1.
